// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encodings and default operand width for serial_subtractor.
package serial_subtractor_pkg;
   localparam int WIDTH_DEFAULT = 8;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: combinational 1-bit full-subtractor cell, d = x - y - bin with borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, with start/done handshake.
// Defining SERIAL_SUB_OVF_EN adds the ovf port (two's-complement signed overflow).
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   state_t state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [CW-1:0] cnt;
   logic bin, d, bout, last;
   full_subtractor u_fs (
      .x   (a_sr[0]),
      .y   (b_sr[0]),
      .bin (bin),
      .d   (d),
      .bout(bout)
   );
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state == S_SHIFT;
   assign done = state == S_DONE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = S_IDLE;
      state_nx = state == S_IDLE  ? (start ? S_SHIFT : S_IDLE) :
                 state == S_SHIFT ? (last ? S_DONE : S_SHIFT) : S_IDLE;
   end
`ifdef SERIAL_SUB_OVF_EN
   logic a_msb, b_msb;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == S_IDLE && start) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == S_SHIFT && last) begin
         ovf <= (a_msb != b_msb) && (d != a_msb);
      end
`endif
   // Result registers load on the final shift so diff/borrow are already valid while done is high.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         bin    <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else if (state == S_IDLE && start) begin
         a_sr <= a;
         b_sr <= b;
         bin  <= 1'b0;
         cnt  <= '0;
      end else if (state == S_SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {d, res_sr[WIDTH-1:1]};
         bin    <= bout;
         cnt    <= cnt + CW'(1);
         if (last) begin
            diff   <= {d, res_sr[WIDTH-1:1]};
            borrow <= bout;
         end
      end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations checked against plain integer subtraction.
module tb_serial_subtractor;
   localparam int WIDTH = 8;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [WIDTH-1:0] a = '0, b = '0, diff;
   logic busy, done, borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic ovf;
`endif
   int n_cmp = 0, n_bad = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full operation; optionally re-pulses start with other operands mid-flight.
   task automatic op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit repulse);
      int cyc = 0, bcnt = 0;
      bit seen = 0;
      int sd = int'($signed(av)) - int'($signed(bv));
      logic [WIDTH-1:0] ed = WIDTH'((int'(av) - int'(bv) + 256) % 256);
      logic eb = av < bv;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (repulse && cyc == 3) begin
            start = 1'b1; a = 8'h00; b = 8'h01;
         end else start = 1'b0;
         if (done) seen = 1;
         else if (busy) bcnt++;
      end
      chk("done_cycle", cyc, WIDTH + 1);
      chk("busy_cycles", bcnt, WIDTH);
      chk("diff", diff, ed);
      chk("borrow", borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", ovf, (sd < -128 || sd > 127));
`else
      if (sd > 1000) $display("unreachable %0d", sd);
`endif
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      chk("diff_hold", diff, ed);
   endtask

   initial begin
      int nd;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      @(negedge clk) rst_n = 1'b1;
      op(8'h05, 8'h03, 0);
      op(8'h03, 8'h05, 0);
      op(8'h80, 8'h01, 0);
      op(8'h00, 8'h00, 0);
      op(8'hFF, 8'hFF, 0);
      op(8'h00, 8'h01, 0);
      op(8'h10, 8'h01, 1);
      // Abort mid-operation with an async reset.
      @(negedge clk);
      a = 8'h55; b = 8'h22; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow, 0);
      @(negedge clk) rst_n = 1'b1;
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort_no_done", nd, 0);
      op(8'h55, 8'h22, 0);
      for (int i = 0; i < 25; i++) op(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) == 0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
